psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
//  Receives the 24-bit partial-sum stream leaving the bottom PE of a systolic column (the o_sum
//  chain), accumulates consecutive beats of one output group into a wide signed result, and
//  buffers finished results for the writeback path.
//  Sits between the column tail and the output memory/DMA.
//  Provides valid/ready back-pressure on both sides.
// PARAMETERS
//  SUM_W   24  width of incoming partial sum (two's complement)
//  ACC_W   32  accumulator/result width, ACC_W >= SUM_W
//  DEPTH   8   result FIFO entries, power of two, >= 2
//  LVL_W   $clog2(DEPTH+1)  occupancy width (derived, localparam)
// PORTS
//  clock        in   1       rising-edge clock
//  reset        in   1       asynchronous, active-high reset
//  i_valid      in   1       i_sum beat valid
//  i_sum        in   SUM_W   partial sum from PE column
//  i_last       in   1       beat is the final one of its output group
//  i_clear      in   1       abort the group in progress (synchronous)
//  o_in_ready   out  1       beat is accepted when i_valid && o_in_ready
//  o_valid      out  1       result at FIFO head valid
//  o_data       out  ACC_W   accumulated result
//  o_sat        out  1       result saturated during accumulation
//  i_ready      in   1       downstream pops when o_valid && i_ready
//  o_level      out  LVL_W   FIFO occupancy
//  o_busy       out  1       group in progress (state ACCUM)
// BEHAVIOUR
//  Reset values (async): o_valid=0, o_data=0, o_sat=0, o_level=0, o_busy=0, o_in_ready=1.
//  Reset also sets FSM=IDLE, acc=0, sat flag=0, and FIFO pointers=0.
//  FSM states:
//  - IDLE: no group open.
//  - ACCUM: at least one beat accepted, no i_last yet.
//  Transitions:
//  - IDLE->ACCUM on an accepted beat with i_last=0.
//  - ACCUM->IDLE on an accepted beat with i_last=1, or on i_clear.
//  - IDLE stays IDLE on an accepted beat with i_last=1 (single-beat group).
//  Arithmetic: next = acc(IDLE ? 0 : acc) + sign_extend(i_sum).
//  - Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//  - Any clamp in the group sets the group sat flag.
//  Completion: the accepted beat with i_last pushes {sat, next} into the FIFO on the same edge.
//  - acc and sat are cleared on that edge.
//  - o_valid rises the following cycle if the FIFO was empty.
//  - Latency from last beat to o_valid is 1 cycle.
//  o_in_ready = !full, combinational from registered pointers only; it does not depend on i_ready.
//  - When full, no beat is accepted even if a pop occurs in the same cycle.
//  FIFO ordering:
//  - Push and pop in the same cycle are both performed; o_level is unchanged.
//  - Order is strictly FIFO.
//  - o_data/o_sat are driven from the head entry and are held stable while o_valid && !i_ready.
//  - Pointers wrap modulo DEPTH. A pop on empty and a push on full are impossible by construction.
//  i_clear:
//  - Discards acc/sat and returns to IDLE.
//  - A beat presented in the same cycle is discarded, including a beat with i_last.
//  - FIFO contents are untouched.
//  Back-pressure mid-group: the group stays open in ACCUM. Non-last beats are accepted while !full.
//  Reset mid-operation: open group and all buffered results are lost immediately, with no drain.
//  Beats with i_valid=0 change nothing; i_sum/i_last are don't-care.
// STRUCTURE
//  Shared package pe_pkg:
//  - SUM_W default.
//  - typedef drain_state_e {IDLE, ACCUM}.
//  - sat_add function (signed saturating add).
//  Sub-module psum_fifo:
//  - Parameterised synchronous FIFO, width ACC_W+1, depth DEPTH.
//  - Outputs full, empty, and level.
//  - Same async active-high reset.
//  Top level: FSM, accumulator, and handshake glue.
// TESTING
//  1. Reset, then beats 24'h000010, 24'h000020, 24'h000003(last), i_ready=1.
//     -> o_valid one cycle after the last beat, o_data=32'h00000033, o_sat=0.
//  2. Beats 24'hFFFFFF, 24'h000001(last).
//     -> o_data=32'h00000000. Single beat 24'h800000(last) -> o_data=32'hFF800000.
//  3. ACC_W=24, beats 24'h7FFFFF, 24'h000001(last).
//     -> o_data=24'h7FFFFF, o_sat=1. The next group's o_sat is 0.
//  4. i_ready=0, eight single-beat groups with values 1..8.
//     -> o_level=8, o_in_ready=0, a 9th beat is not accepted.
//     Then i_ready=1 -> 1..8 popped in order on consecutive cycles.
//  5. Beats 5, 6, then i_clear together with 7(last), then 9(last).
//     -> exactly one result, o_data=9.
//  6. FIFO holding 3 results and a group open, then reset pulsed mid-cycle.
//     -> o_valid=0, o_level=0, o_busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and arithmetic helpers for the processing-element column datapath.
// The saturating adder works on 64-bit sign-extended operands and clamps to a w-bit range.
package pe_pkg;

  localparam int SUM_W_DEF = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_res_t;

  // Operands must already be sign-extended to 64 bits; w is at most 63.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int                 w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sat_res_t           r;
    s     = {a[63], a} + {b[63], b};
    hi    = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo    = -(65'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = s[63:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.val = hi[63:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.val = lo[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Result FIFO for the partial-sum drain: circular buffer with an occupancy counter.
// The head entry is presented combinationally; an empty FIFO presents zero.
module psum_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (i_push) wr_d = wr_q + PTR_W'(1);
    if (i_pop)  rd_d = rd_q + PTR_W'(1);
    case ({i_push, i_pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_push) mem[wr_q] <= i_data;
  end

  assign o_full  = (lvl_q == LVL_W'(DEPTH));
  assign o_empty = (lvl_q == '0);
  assign o_level = lvl_q;
  assign o_data  = o_empty ? '0 : mem[rd_q];

endmodule

// File: rtl/psum_drain.sv
// Column-tail drain: accumulates partial-sum beats of one output group with saturation
// and queues each finished {sat, result} for the writeback path.
module psum_drain
  import pe_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int ACC_W = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [SUM_W-1:0]           i_sum,
  input  logic                       i_last,
  input  logic                       i_clear,
  output logic                       o_in_ready,
  output logic                       o_valid,
  output logic [ACC_W-1:0]           o_data,
  output logic                       o_sat,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_busy
);

  localparam int LVL_W = $clog2(DEPTH + 1);

  drain_state_e       state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   base_acc;
  logic signed [63:0] acc_ext, sum_ext;
  sat_res_t           add_res;
  logic               grp_sat;
  logic               accept, push, pop;
  logic               fifo_full, fifo_empty;
  logic [ACC_W:0]     push_data, head_data;
  logic [LVL_W-1:0]   fifo_level;
  logic               unused_hi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign accept = i_valid && !fifo_full;
  assign pop    = !fifo_empty && i_ready;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    push     = 1'b0;
    // A new group starts from zero regardless of any stale accumulator contents.
    base_acc = (state_q == ACCUM) ? acc_q : '0;
    acc_ext  = {{(64-ACC_W){base_acc[ACC_W-1]}}, base_acc};
    sum_ext  = {{(64-SUM_W){i_sum[SUM_W-1]}}, i_sum};
    add_res  = sat_add(acc_ext, sum_ext, ACC_W);
    grp_sat  = ((state_q == ACCUM) && sat_q) || add_res.sat;
    if (i_clear) begin
      state_d = IDLE;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      if (i_last) begin
        push    = 1'b1;
        state_d = IDLE;
        acc_d   = '0;
        sat_d   = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = add_res.val[ACC_W-1:0];
        sat_d   = grp_sat;
      end
    end
  end

  assign push_data = {grp_sat, add_res.val[ACC_W-1:0]};
  // Clamped results are pure sign extension above ACC_W.
  assign unused_hi = ^add_res.val[63:ACC_W];

  psum_fifo #(
    .W     (ACC_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (push),
    .i_data  (push_data),
    .i_pop   (pop),
    .o_data  (head_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  assign o_in_ready      = !fifo_full;
  assign o_valid         = !fifo_empty;
  assign {o_sat, o_data} = head_data;
  assign o_level         = fifo_level;
  assign o_busy          = (state_q == ACCUM);

endmodule

// File: tb/tb_psum_drain.sv
// Randomized and directed bench for psum_drain, checked against a queue-based group/FIFO model.
// A second instance with a 24-bit accumulator covers the saturation case.
module tb_psum_drain;

  localparam int DEPTH = 8;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0, i_last = 1'b0, i_clear = 1'b0, i_ready = 1'b0;
  logic [23:0] i_sum = '0;
  logic        o_in_ready, o_valid, o_sat, o_busy;
  logic [31:0] o_data;
  logic [3:0]  o_level;

  logic        b_valid = 1'b0, b_last = 1'b0, b_clear = 1'b0, b_ready = 1'b0;
  logic [23:0] b_sum = '0;
  logic        b_in_ready, b_ovalid, b_sat, b_busy;
  logic [23:0] b_data;
  logic [3:0]  b_level;

  always #5 clock = ~clock;

  psum_drain #(.SUM_W(24), .ACC_W(32), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_sum(i_sum), .i_last(i_last),
    .i_clear(i_clear), .o_in_ready(o_in_ready), .o_valid(o_valid), .o_data(o_data),
    .o_sat(o_sat), .i_ready(i_ready), .o_level(o_level), .o_busy(o_busy)
  );

  psum_drain #(.SUM_W(24), .ACC_W(24), .DEPTH(DEPTH)) dut_b (
    .clock(clock), .reset(reset), .i_valid(b_valid), .i_sum(b_sum), .i_last(b_last),
    .i_clear(b_clear), .o_in_ready(b_in_ready), .o_valid(b_ovalid), .o_data(b_data),
    .o_sat(b_sat), .i_ready(b_ready), .o_level(b_level), .o_busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: open-group flag, accumulator and FIFO of finished results.
  longint mq_val[$];
  bit     mq_sat[$];
  bit     m_open = 1'b0;
  bit     m_sat  = 1'b0;
  longint m_acc  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_val.delete();
    mq_sat.delete();
    m_open = 1'b0;
    m_sat  = 1'b0;
    m_acc  = 0;
  endtask

  task automatic model_step(input bit v, input logic [23:0] s, input bit l, input bit c, input bit r);
    bit     full;
    bit     accept;
    bit     pop;
    longint sum;
    bit     sat;
    full   = (mq_val.size() == DEPTH);
    accept = v && !full;
    pop    = (mq_val.size() > 0) && r;
    if (pop) begin
      $display("[TB] pop data=%08h sat=%0d", 32'(mq_val[0]), mq_sat[0]);
      void'(mq_val.pop_front());
      void'(mq_sat.pop_front());
    end
    if (c) begin
      m_open = 1'b0;
      m_acc  = 0;
      m_sat  = 1'b0;
    end else if (accept) begin
      sum = (m_open ? m_acc : 0) + longint'($signed(s));
      sat = m_open && m_sat;
      if (sum > MAXV) begin
        sum = MAXV;
        sat = 1'b1;
      end else if (sum < MINV) begin
        sum = MINV;
        sat = 1'b1;
      end
      if (l) begin
        mq_val.push_back(sum);
        mq_sat.push_back(sat);
        m_open = 1'b0;
        m_acc  = 0;
        m_sat  = 1'b0;
      end else begin
        m_open = 1'b1;
        m_acc  = sum;
        m_sat  = sat;
      end
    end
  endtask

  task automatic model_check();
    check("level", 64'(o_level), 64'(mq_val.size()));
    check("in_ready", 64'(o_in_ready), 64'(mq_val.size() < DEPTH));
    check("valid", 64'(o_valid), 64'(mq_val.size() > 0));
    check("busy", 64'(o_busy), 64'(m_open));
    if (mq_val.size() > 0) begin
      check("data", 64'(o_data), mq_val[0] & 64'hFFFF_FFFF);
      check("sat", 64'(o_sat), 64'(mq_sat[0]));
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the next rising edge.
  task automatic cycle(input bit v, input logic [23:0] s, input bit l, input bit c, input bit r);
    i_valid = v;
    i_sum   = s;
    i_last  = l;
    i_clear = c;
    i_ready = r;
    model_step(v, s, l, c, r);
    @(negedge clock);
    model_check();
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_sat", 64'(o_sat), 64'd0);
    check("rst_level", 64'(o_level), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_in_ready", 64'(o_in_ready), 64'd1);
    check("rst_b_valid", 64'(b_ovalid), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // 24-bit accumulator: saturation sets sat, and the following group starts clean.
    b_valid = 1'b1; b_sum = 24'h7FFFFF; b_last = 1'b0;
    @(negedge clock);
    b_sum = 24'h000001; b_last = 1'b1;
    @(negedge clock);
    b_valid = 1'b0;
    check("t3_valid", 64'(b_ovalid), 64'd1);
    check("t3_data", 64'(b_data), 64'h7FFFFF);
    check("t3_sat", 64'(b_sat), 64'd1);
    b_ready = 1'b1;
    b_valid = 1'b1; b_sum = 24'h000001; b_last = 1'b0;
    @(negedge clock);
    b_ready = 1'b0;
    b_sum = 24'h000002; b_last = 1'b1;
    @(negedge clock);
    b_valid = 1'b0;
    check("t3_next_level", 64'(b_level), 64'd1);
    check("t3_next_data", 64'(b_data), 64'h000003);
    check("t3_next_sat", 64'(b_sat), 64'd0);

    // Three-beat group.
    cycle(1, 24'h000010, 0, 0, 1);
    cycle(1, 24'h000020, 0, 0, 1);
    check("t1_busy", 64'(o_busy), 64'd1);
    cycle(1, 24'h000003, 1, 0, 1);
    check("t1_valid", 64'(o_valid), 64'd1);
    check("t1_data", 64'(o_data), 64'h33);
    check("t1_sat", 64'(o_sat), 64'd0);
    cycle(0, 0, 0, 0, 1);

    // Sign handling.
    cycle(1, 24'hFFFFFF, 0, 0, 1);
    cycle(1, 24'h000001, 1, 0, 1);
    check("t2_zero", 64'(o_data), 64'h0);
    cycle(1, 24'h800000, 1, 0, 1);
    check("t2_neg", 64'(o_data), 64'hFF80_0000);
    cycle(0, 0, 0, 0, 1);

    // Fill the FIFO under back-pressure, then drain in order.
    for (int k = 1; k <= 8; k++) cycle(1, 24'(k), 1, 0, 0);
    check("t4_level", 64'(o_level), 64'd8);
    check("t4_in_ready", 64'(o_in_ready), 64'd0);
    cycle(1, 24'd9, 1, 0, 0);
    check("t4_no_accept", 64'(o_level), 64'd8);
    for (int k = 1; k <= 8; k++) begin
      check("t4_order", 64'(o_data), 64'(k));
      cycle(0, 0, 0, 0, 1);
    end
    check("t4_empty", 64'(o_level), 64'd0);

    // Clear discards the open group and the beat presented with it.
    cycle(1, 24'd5, 0, 0, 0);
    cycle(1, 24'd6, 0, 0, 0);
    cycle(1, 24'd7, 1, 1, 0);
    cycle(1, 24'd9, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("t5_level", 64'(o_level), 64'd1);
    check("t5_data", 64'(o_data), 64'd9);
    cycle(0, 0, 0, 0, 1);
    check("t5_drained", 64'(o_level), 64'd0);

    // Reset between clock edges drops everything at once.
    for (int k = 1; k <= 3; k++) cycle(1, 24'(k), 1, 0, 0);
    cycle(1, 24'd4, 0, 0, 0);
    check("t6_pre_busy", 64'(o_busy), 64'd1);
    i_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_valid", 64'(o_valid), 64'd0);
    check("t6_level", 64'(o_level), 64'd0);
    check("t6_busy", 64'(o_busy), 64'd0);
    model_reset();
    #1 reset = 1'b0;
    @(negedge clock);
    model_check();

    // Random traffic: short groups, then long near-max groups that saturate.
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
    end
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 9) < 9,
            ($urandom_range(0, 3) != 0) ? 24'h7FFFFF : (($urandom_range(0, 1) != 0) ? 24'h800000 : 24'($urandom)),
            $urandom_range(0, 399) == 0, 1'b0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
